// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Divides clk_in down to the pixel rate, runs the horizontal/vertical
// counters, decodes sync/blank, and registers the application's colour
// together with sync/blank so every connector pin changes on one edge.
// Handshake: none. The colour source is a combinational function of
// (horizontal, vertical) and must settle within one clk_in of a counter change.
// Geometry limit: H_TOTAL and V_TOTAL must each be <= 1024 (10-bit counters).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [23:0] color_in,
  output logic [9:0]  horizontal,
  output logic [9:0]  vertical,
  output logic        pixel_tick,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_clk,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Divider counter is at least one bit wide so CLK_DIV=1 still elaborates;
  // in that case it stays at zero and the tick is permanently high.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic             VGA_CLK_EN = (CLK_DIV > 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits so a sync window ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = !SYNC_ON;

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_next;
  logic             w_tick;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_active;
  logic             w_hs_int;
  logic             w_vs_int;
  logic [23:0]      r_rgb;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank_n;
  logic             r_vga_clk;
  logic             r_frame_start;

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_div_next = w_tick ? '0 : r_div_cnt + DIV_W'(1);
  assign w_h_last   = (r_h == H_LAST);
  assign w_v_last   = (r_v == V_LAST);

  // Raster decode from the current (pre-edge) counter values.
  always_comb begin
    w_active = ({1'b0, r_h} < H_ACT_END) && ({1'b0, r_v} < V_ACT_END);
    w_hs_int = ({1'b0, r_h} >= H_SYNC_BEG) && ({1'b0, r_h} < H_SYNC_END);
    w_vs_int = ({1'b0, r_v} >= V_SYNC_BEG) && ({1'b0, r_v} < V_SYNC_END);
  end

  // Pixel-rate divider; vga_clk follows the divider phase so it is low in the
  // first half of each pixel period and high in the second half.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_div_cnt <= '0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_vga_clk <= VGA_CLK_EN && (w_div_next >= DIV_HALF);
    end
  end

  // Horizontal/vertical counters; vertical steps only when horizontal wraps.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // Output stage: colour, sync and blank for the pixel being left on this tick.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_rgb     <= '0;
      r_hs      <= SYNC_OFF;
      r_vs      <= SYNC_OFF;
      r_blank_n <= 1'b0;
    end else if (w_tick) begin
      r_rgb     <= w_active ? color_in : 24'd0;
      r_hs      <= w_hs_int ? SYNC_ON : SYNC_OFF;
      r_vs      <= w_vs_int ? SYNC_ON : SYNC_OFF;
      r_blank_n <= w_active;
    end
  end

  // One-clk pulse after the edge that wraps the last pixel of the frame to (0,0).
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && w_h_last && w_v_last;
    end
  end

  assign horizontal  = r_h;
  assign vertical    = r_v;
  assign pixel_tick  = w_tick;
  assign vga_r       = r_rgb[23:16];
  assign vga_g       = r_rgb[15:8];
  assign vga_b       = r_rgb[7:0];
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign vga_clk     = r_vga_clk;
  assign frame_start = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the VGA raster: pixel-rate enable, horizontal/vertical pixel counters, sync and blanking signals.
- Drives the horizontal/vertical coordinates consumed by the colour-application logic.
- Takes that logic's 24-bit colour back and registers it with sync/blank, so all DAC/connector outputs change on the same edge.
- Default timing is 640x480@60 from a 50 MHz clock.

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: hsync pulse width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vsync pulse width (lines)
- V_BP, 33: vertical back porch (lines)
- CLK_DIV, 2: clk_in cycles per pixel (>=1)
- SYNC_POL, 0: active level of hs/vs (0 = active-low)

Ports:
- clk_in  in  1  system clock
- reset_in  in  1  asynchronous reset, active-high
- color_in  in  24  {R,G,B} for the current (horizontal, vertical), combinational from the application
- horizontal  out  10  current pixel column counter
- vertical  out  10  current line counter
- pixel_tick  out  1  one-clk pulse, pixel-rate enable
- vga_r, vga_g, vga_b  out  8 each  registered colour
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_blank_n  out  1  high during the active area
- vga_clk  out  1  pixel clock for the DAC
- frame_start  out  1  one-clk pulse at frame wrap

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pixel_tick is combinational, = (div_cnt==CLK_DIV-1). With CLK_DIV=1, pixel_tick is constantly 1.
- vga_clk: registered; high when div_cnt >= CLK_DIV/2 (integer division), else low. With CLK_DIV=1, vga_clk = 0 and the board uses clk_in.
- Counters advance only on a clk edge with pixel_tick=1:
  - h wraps H_TOTAL-1 -> 0 and increments v in the same edge.
  - v wraps V_TOTAL-1 -> 0 only when h also wraps.
  - horizontal = h and vertical = v, driven directly from the counter registers.
- Decode, combinational from the counters:
  - active = h<H_ACTIVE && v<V_ACTIVE
  - hs_int = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs_int = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (line-based, independent of h)
- Output stage, updated only on pixel_tick edges, sampling the pre-edge counter values:
  - vga_r/g/b = active ? color_in : 0
  - vga_hs = hs_int ? SYNC_POL : !SYNC_POL
  - vga_vs likewise from vs_int
  - vga_blank_n = active
- Latency: outputs for pixel (h,v) appear on the same edge the counters leave (h,v) and hold one pixel period (CLK_DIV clks). color_in must settle within one clk of a counter change.
- frame_start: registered; high for exactly one clk_in cycle following the edge where (h,v) goes (H_TOTAL-1,V_TOTAL-1) -> (0,0). Never asserted by reset release.
- Reset (asynchronous, any time including mid-frame):
  - div_cnt, h, v = 0
  - vga_r/g/b = 0; vga_blank_n = 0; vga_clk = 0; frame_start = 0
  - vga_hs/vga_vs = !SYNC_POL
- After reset release, the first pixel_tick occurs CLK_DIV edges later and the raster starts at (0,0) without a frame_start pulse.
- Width rule: H_TOTAL and V_TOTAL must each be <= 1024. No internal counter saturates; all counters wrap only as specified.

Test Plan:
1. Hold reset_in 5 clks, then sample: horizontal=0, vertical=0, vga_hs=1, vga_vs=1, blank_n=0, rgb=0, frame_start=0. After release, h=1 exactly 2 clks later (CLK_DIV=2).
2. Free-run one line: h period 1600 clks. vga_hs low for exactly 192 clks, starting on the edge where h goes 656->657. blank_n falls on the edge h 640->641. vertical increments only at h wrap 799->0.
3. Full frame: vga_vs low for exactly 2 lines (3200 clks), lines 490-491. frame_start pulses once every 840000 clks, width 1 clk.
4. color_in = {horizontal[7:0], vertical[7:0], 8'hAA}:
   - at v=3, after the h 5->6 edge: vga_r=5, vga_g=3, vga_b=AA
   - pixel (640,3): rgb=0
   - pixel (100,480): rgb=0
5. Assert reset_in asynchronously mid-line at (300,200), between clock edges: all outputs reach reset values without waiting for an edge. After release, the raster restarts at (0,0) with no frame_start pulse.
6. Parameter override CLK_DIV=1, SYNC_POL=1: h increments every clk, vga_hs high for 96 clks per 800, vga_clk constant 0.
